// File: rtl/toast_wb_unit.sv
// -----------------------------------------------------------------------------
// toast_wb_unit
//
// Writeback stage of the Toast pipeline. Registers the MEM/WB boundary, waits
// for variable-latency data-memory load responses (stalling upstream while it
// waits), aligns and sign/zero-extends load data, suppresses writes to x0 and
// emits a one-cycle retire pulse per completed instruction.
//
// Optional feature: define TOAST_WB_INSTRET_EN to build a CNT_W-bit
// retired-instruction counter. Without it WB_instret_o is tied to zero.
//
// Parameters
//   XLEN       datapath width (>= 32)
//   RF_ADDR_W  register-file address width
//   CNT_W      retired-instruction counter width
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   MEM_valid_i         instruction presented by MEM
//   MEM_rd_addr_i       destination register
//   MEM_alu_result_i    ALU result (non-load write data)
//   MEM_memtoreg_i      1 = load, result comes from DMEM
//   MEM_rd_wr_en_i      instruction writes rd
//   MEM_mem_op_i        load funct3 (LB/LH/LW/LBU/LHU, others treated as LW)
//   MEM_byte_off_i      low address bits of the load
//   DMEM_rvalid_i       load data valid this cycle
//   DMEM_rdata_i        raw load word
//   WB_stall_o          upstream must hold MEM outputs
//   WB_rd_addr_o        register-file write address
//   WB_rd_wr_data_o     register-file write data
//   WB_rd_wr_en_o       register-file write strobe
//   WB_retire_o         one-cycle pulse per completed instruction
//   WB_instret_o        retired-instruction count
// -----------------------------------------------------------------------------
module toast_wb_unit #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MEM_valid_i,
    input  logic [RF_ADDR_W-1:0] MEM_rd_addr_i,
    input  logic [XLEN-1:0]      MEM_alu_result_i,
    input  logic                 MEM_memtoreg_i,
    input  logic                 MEM_rd_wr_en_i,
    input  logic [2:0]           MEM_mem_op_i,
    input  logic [1:0]           MEM_byte_off_i,
    input  logic                 DMEM_rvalid_i,
    input  logic [XLEN-1:0]      DMEM_rdata_i,
    output logic                 WB_stall_o,
    output logic [RF_ADDR_W-1:0] WB_rd_addr_o,
    output logic [XLEN-1:0]      WB_rd_wr_data_o,
    output logic                 WB_rd_wr_en_o,
    output logic                 WB_retire_o,
    output logic [CNT_W-1:0]     WB_instret_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                 state_q,     state_d;

    // Pending register: the most recently accepted instruction.
    logic [RF_ADDR_W-1:0]   pend_rd_q,   pend_rd_d;
    logic                   pend_we_q,   pend_we_d;
    logic [2:0]             pend_op_q,   pend_op_d;
    logic [1:0]             pend_off_q,  pend_off_d;
    logic [XLEN-1:0]        pend_alu_q,  pend_alu_d;
    // Set when a non-load was accepted on the same edge a load completed; the
    // non-load sits in the pending register and is written one edge later so
    // no result is ever lost.
    logic                   defer_q,     defer_d;

    logic [RF_ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic [XLEN-1:0]        wr_data_q,   wr_data_d;
    logic                   wr_en_q,     wr_en_d;
    logic                   retire_q,    retire_d;

    logic                   accept;
    logic                   emitted;

    // Extract and extend the addressed byte/half from the low 32 bits.
    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  fmt_load = XLEN'($signed(b));
            3'b100:  fmt_load = XLEN'(b);
            3'b001:  fmt_load = XLEN'($signed(h));
            3'b101:  fmt_load = XLEN'(h);
            default: fmt_load = XLEN'($signed(w));
        endcase
    endfunction

    // Combinational stall lets a new load be accepted in the cycle the
    // previous one returns, giving back-to-back loads with no bubble.
    assign WB_stall_o = (state_q == S_WAIT) && !DMEM_rvalid_i;
    assign accept     = MEM_valid_i && !WB_stall_o;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        pend_op_d  = pend_op_q;
        pend_off_d = pend_off_q;
        pend_alu_d = pend_alu_q;
        defer_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        retire_d   = 1'b0;
        emitted    = 1'b0;

        // Complete whatever the pending register holds (at most one per edge).
        case (state_q)
            S_IDLE: begin
                if (defer_q) begin
                    rd_addr_d = pend_rd_q;
                    wr_data_d = pend_alu_q;
                    wr_en_d   = pend_we_q && (pend_rd_q != '0);
                    retire_d  = 1'b1;
                    emitted   = 1'b1;
                end
            end
            S_WAIT: begin
                if (DMEM_rvalid_i) begin
                    rd_addr_d = pend_rd_q;
                    wr_data_d = fmt_load(pend_op_q, pend_off_q, DMEM_rdata_i[31:0]);
                    wr_en_d   = pend_we_q && (pend_rd_q != '0);
                    retire_d  = 1'b1;
                    emitted   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Then accept a new instruction.
        if (accept) begin
            pend_rd_d  = MEM_rd_addr_i;
            pend_we_d  = MEM_rd_wr_en_i;
            pend_op_d  = MEM_mem_op_i;
            pend_off_d = MEM_byte_off_i;
            pend_alu_d = MEM_alu_result_i;
            if (MEM_memtoreg_i) begin
                state_d = S_WAIT;
            end else if (emitted) begin
                defer_d = 1'b1;
            end else begin
                rd_addr_d = MEM_rd_addr_i;
                wr_data_d = MEM_alu_result_i;
                wr_en_d   = MEM_rd_wr_en_i && (MEM_rd_addr_i != '0);
                retire_d  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pend_rd_q  <= '0;
            pend_we_q  <= 1'b0;
            pend_op_q  <= '0;
            pend_off_q <= '0;
            pend_alu_q <= '0;
            defer_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            pend_op_q  <= pend_op_d;
            pend_off_q <= pend_off_d;
            pend_alu_q <= pend_alu_d;
            defer_q    <= defer_d;
            rd_addr_q  <= rd_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            retire_q   <= retire_d;
        end
    end

    assign WB_rd_addr_o    = rd_addr_q;
    assign WB_rd_wr_data_o = wr_data_q;
    assign WB_rd_wr_en_o   = wr_en_q;
    assign WB_retire_o     = retire_q;

`ifdef TOAST_WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;

    // Counts on the same edge the retire pulse is launched, so the output
    // already includes the pulse visible in the current cycle. Wraps freely.
    always_comb begin
        instret_d = instret_q;
        if (retire_d) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign WB_instret_o = instret_q;
`else
    assign WB_instret_o = '0;
`endif

endmodule

// File: tb/tb_toast_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_toast_wb_unit
//
// Self-checking bench for toast_wb_unit: directed scenarios with exact cycle
// timing, then a randomized run checked against an in-order scoreboard of
// expected register-file writes.
// -----------------------------------------------------------------------------
module tb_toast_wb_unit;

    localparam int XLEN = 32;
    localparam int RFW  = 5;
    localparam int CW   = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            MEM_valid_i = 1'b0;
    logic [RFW-1:0]  MEM_rd_addr_i = '0;
    logic [XLEN-1:0] MEM_alu_result_i = '0;
    logic            MEM_memtoreg_i = 1'b0;
    logic            MEM_rd_wr_en_i = 1'b0;
    logic [2:0]      MEM_mem_op_i = '0;
    logic [1:0]      MEM_byte_off_i = '0;
    logic            DMEM_rvalid_i = 1'b0;
    logic [XLEN-1:0] DMEM_rdata_i = '0;
    logic            WB_stall_o;
    logic [RFW-1:0]  WB_rd_addr_o;
    logic [XLEN-1:0] WB_rd_wr_data_o;
    logic            WB_rd_wr_en_o;
    logic            WB_retire_o;
    logic [CW-1:0]   WB_instret_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [RFW-1:0]  rd;
        logic [XLEN-1:0] data;
        logic            we;
    } wb_rec_t;

    wb_rec_t exp_q[$];

    toast_wb_unit #(.XLEN(XLEN), .RF_ADDR_W(RFW), .CNT_W(CW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .MEM_valid_i      (MEM_valid_i),
        .MEM_rd_addr_i    (MEM_rd_addr_i),
        .MEM_alu_result_i (MEM_alu_result_i),
        .MEM_memtoreg_i   (MEM_memtoreg_i),
        .MEM_rd_wr_en_i   (MEM_rd_wr_en_i),
        .MEM_mem_op_i     (MEM_mem_op_i),
        .MEM_byte_off_i   (MEM_byte_off_i),
        .DMEM_rvalid_i    (DMEM_rvalid_i),
        .DMEM_rdata_i     (DMEM_rdata_i),
        .WB_stall_o       (WB_stall_o),
        .WB_rd_addr_o     (WB_rd_addr_o),
        .WB_rd_wr_data_o  (WB_rd_wr_data_o),
        .WB_rd_wr_en_o    (WB_rd_wr_en_o),
        .WB_retire_o      (WB_retire_o),
        .WB_instret_o     (WB_instret_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference load formatting from the ISA rules using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (op)
            3'd0, 3'd4: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (op == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (op == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef TOAST_WB_INSTRET_EN
        return CW'(n % 16);
`else
        return CW'(n - n);
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        MEM_valid_i = 1'b0;
        DMEM_rvalid_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, WB_retire_o, WB_instret_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%0b rd=%0d data=%h we=%0b ret=%0b cnt=%0d, want all 0",
                     WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, WB_retire_o, WB_instret_o);
        end
        do_reset();
    endtask

    task automatic drive_instr(input logic ld, input logic [4:0] rd, input logic [31:0] alu,
                               input logic we, input logic [2:0] op, input logic [1:0] off);
        MEM_valid_i = 1'b1;
        MEM_memtoreg_i = ld;
        MEM_rd_addr_i = rd;
        MEM_alu_result_i = alu;
        MEM_rd_wr_en_i = we;
        MEM_mem_op_i = op;
        MEM_byte_off_i = off;
    endtask

    task automatic check_out(input string name, input logic [4:0] rd, input logic [31:0] data,
                             input logic we, input logic ret);
        n_vec++;
        if (WB_rd_addr_o !== rd || WB_rd_wr_data_o !== data || WB_rd_wr_en_o !== we || WB_retire_o !== ret) begin
            n_err++;
            $display("FAIL %s: got rd=%0d data=%h we=%0b ret=%0b, want rd=%0d data=%h we=%0b ret=%0b",
                     name, WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, WB_retire_o, rd, data, we, ret);
        end
    endtask

    task automatic check_stall(input string name, input logic want);
        #1;
        n_vec++;
        if (WB_stall_o !== want) begin
            n_err++;
            $display("FAIL %s: stall got %0b want %0b", name, WB_stall_o, want);
        end
    endtask

    task automatic test_alu();
        drive_instr(1'b0, 5'd5, 32'h1234_5678, 1'b1, 3'd0, 2'd0);
        step();
        MEM_valid_i = 1'b0;
        check_out("alu_write", 5'd5, 32'h1234_5678, 1'b1, 1'b1);
        step();
        check_out("alu_idle_after", 5'd5, 32'h1234_5678, 1'b0, 1'b0);
    endtask

    // Accept a load, return data lat cycles after the accept edge.
    task automatic run_load(input string name, input logic [2:0] op, input logic [1:0] off,
                            input logic [31:0] rdata, input logic [4:0] rd, input int lat,
                            input logic [31:0] want);
        logic [4:0]  prev_rd;
        logic [31:0] prev_data;
        prev_rd = WB_rd_addr_o;
        prev_data = WB_rd_wr_data_o;
        drive_instr(1'b1, rd, $urandom, 1'b1, op, off);
        step();
        MEM_valid_i = 1'b0;
        check_out({name, "_accept"}, prev_rd, prev_data, 1'b0, 1'b0);
        for (int i = 1; i < lat; i++) begin
            check_stall({name, "_stall"}, 1'b1);
            step();
        end
        DMEM_rvalid_i = 1'b1;
        DMEM_rdata_i = rdata;
        check_stall({name, "_rvalid_stall"}, 1'b0);
        step();
        DMEM_rvalid_i = 1'b0;
        check_out(name, rd, want, 1'b1, 1'b1);
    endtask

    task automatic test_loads();
        run_load("lb",  3'b000, 2'd3, 32'h80FF_FF7F, 5'd7, 3, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 2'd3, 32'h80FF_FF7F, 5'd7, 3, 32'h0000_0080);
        run_load("lh",  3'b001, 2'd2, 32'h8001_0000, 5'd8, 1, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 2'd2, 32'h8001_0000, 5'd8, 2, 32'h0000_8001);
        run_load("lw",  3'b010, 2'd0, 32'h8001_0000, 5'd9, 1, 32'h8001_0000);
        run_load("lb_off0", 3'b000, 2'd0, 32'h0000_00F0, 5'd3, 1, 32'hFFFF_FFF0);
        run_load("undef_lw", 3'b111, 2'd1, 32'hDEAD_BEEF, 5'd4, 1, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back();
        drive_instr(1'b1, 5'd10, 32'h0, 1'b1, 3'b010, 2'd0);
        step();
        drive_instr(1'b1, 5'd11, 32'h0, 1'b1, 3'b100, 2'd1);
        DMEM_rvalid_i = 1'b1;
        DMEM_rdata_i = 32'hAAAA_5555;
        check_stall("b2b_no_stall", 1'b0);
        step();
        MEM_valid_i = 1'b0;
        DMEM_rdata_i = 32'h0000_9900;
        check_out("b2b_first", 5'd10, 32'hAAAA_5555, 1'b1, 1'b1);
        step();
        DMEM_rvalid_i = 1'b0;
        check_out("b2b_second", 5'd11, 32'h0000_0099, 1'b1, 1'b1);
    endtask

    task automatic test_x0();
        drive_instr(1'b0, 5'd0, 32'hCAFE_F00D, 1'b1, 3'd0, 2'd0);
        step();
        MEM_valid_i = 1'b0;
        check_out("x0_write", 5'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        drive_instr(1'b0, 5'd9, 32'h5A5A_5A5A, 1'b1, 3'd0, 2'd0);
        step();
        drive_instr(1'b1, 5'd12, 32'h0, 1'b1, 3'b010, 2'd0);
        step();
        MEM_valid_i = 1'b0;
        check_stall("wait_before_reset", 1'b1);
        #1;
        rst_i = 1'b1;
        #1;
        n_vec++;
        if ({WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, WB_retire_o, WB_instret_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got stall=%0b rd=%0d data=%h we=%0b ret=%0b, want all 0",
                     WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, WB_retire_o);
        end
        #1;
        rst_i = 1'b0;
        DMEM_rvalid_i = 1'b1;
        DMEM_rdata_i = 32'h1111_2222;
        step();
        DMEM_rvalid_i = 1'b0;
        check_out("dropped_load", 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_instret_wrap();
        do_reset();
        drive_instr(1'b0, 5'd1, 32'h1, 1'b1, 3'd0, 2'd0);
        for (int i = 0; i < 17; i++) step();
        MEM_valid_i = 1'b0;
        n_vec++;
        if (WB_instret_o !== exp_cnt(17)) begin
            n_err++;
            $display("FAIL instret_wrap: got %0d want %0d", WB_instret_o, exp_cnt(17));
        end
    endtask

    task automatic test_random(input int cycles);
        bit          outst;
        bit          held;
        bit          exp_stall;
        logic [4:0]  prd;
        logic        pwe;
        logic [2:0]  pop;
        logic [1:0]  poff;
        wb_rec_t     r;
        int          pushed;
        do_reset();
        exp_q.delete();
        outst = 0; held = 0; pushed = 0;
        prd = '0; pwe = 0; pop = '0; poff = '0;
        for (int c = 0; c < cycles + 8; c++) begin
            if (!held) begin
                MEM_valid_i = (c < cycles) && ($urandom_range(0, 2) != 0);
                MEM_memtoreg_i = $urandom_range(0, 1) == 1;
                MEM_rd_addr_i = RFW'($urandom_range(0, 31));
                MEM_alu_result_i = $urandom;
                MEM_rd_wr_en_i = $urandom_range(0, 3) != 0;
                MEM_mem_op_i = 3'($urandom_range(0, 7));
                MEM_byte_off_i = 2'($urandom_range(0, 3));
            end
            DMEM_rvalid_i = outst ? ((c >= cycles) || ($urandom_range(0, 2) == 0))
                                  : ($urandom_range(0, 3) == 0);
            DMEM_rdata_i = $urandom;
            exp_stall = outst && !DMEM_rvalid_i;
            check_stall("rand_stall", exp_stall);
            if (outst && DMEM_rvalid_i) begin
                exp_q.push_back('{prd, ref_load(pop, poff, DMEM_rdata_i), pwe && (prd != 0)});
                pushed++;
                outst = 0;
            end
            if (MEM_valid_i && !exp_stall) begin
                if (MEM_memtoreg_i) begin
                    outst = 1;
                    prd = MEM_rd_addr_i; pwe = MEM_rd_wr_en_i;
                    pop = MEM_mem_op_i; poff = MEM_byte_off_i;
                end else begin
                    exp_q.push_back('{MEM_rd_addr_i, MEM_alu_result_i,
                                      MEM_rd_wr_en_i && (MEM_rd_addr_i != 0)});
                    pushed++;
                end
            end
            held = MEM_valid_i && exp_stall;
            step();
            n_vec++;
            if (WB_retire_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_retire: unexpected retire rd=%0d data=%h", WB_rd_addr_o, WB_rd_wr_data_o);
                end else begin
                    r = exp_q.pop_front();
                    if (WB_rd_addr_o !== r.rd || WB_rd_wr_data_o !== r.data || WB_rd_wr_en_o !== r.we) begin
                        n_err++;
                        $display("FAIL rand_write: got rd=%0d data=%h we=%0b want rd=%0d data=%h we=%0b",
                                 WB_rd_addr_o, WB_rd_wr_data_o, WB_rd_wr_en_o, r.rd, r.data, r.we);
                    end
                end
            end else if (WB_rd_wr_en_o !== 1'b0) begin
                n_err++;
                $display("FAIL rand_we_no_retire: we=%0b ret=%0b", WB_rd_wr_en_o, WB_retire_o);
            end
        end
        MEM_valid_i = 1'b0;
        DMEM_rvalid_i = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || outst) begin
            n_err++;
            $display("FAIL rand_drain: %0d writes never retired (load outstanding %0b)", exp_q.size(), outst);
        end
        n_vec++;
        if (WB_instret_o !== exp_cnt(pushed)) begin
            n_err++;
            $display("FAIL rand_instret: got %0d want %0d", WB_instret_o, exp_cnt(pushed));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_x0();
        test_reset_mid_wait();
        test_instret_wrap();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
